// File: rtl/uart_echo_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo_pkg
// Shared definitions for the UART echo/transform stage:
//   mode_e         - transform selector codes driven on the 'mode' port
//   ST_IDLE/ST_SEND - TX FSM state encodings
// -----------------------------------------------------------------------------
package uart_echo_fifo_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_INV  = 2'b11
  } mode_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage : uart_echo_fifo_pkg

// File: rtl/uart_echo_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo_if
// Receive strobe and transmit valid/ready handshake of the echo stage.
//   rx_valid/rx_data   - one-cycle strobe carrying a received word
//   tx_valid/tx_data   - transformed word offered to the transmitter
//   tx_ready           - transmitter accepts tx_data this cycle
// Modports: master = the UART side (drives rx, consumes tx),
//           slave  = the echo stage.
// -----------------------------------------------------------------------------
interface uart_echo_fifo_if #(
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data
  );
endinterface : uart_echo_fifo_if

// File: rtl/uart_echo_fifo_word_fifo.sv
// -----------------------------------------------------------------------------
// uart_word_fifo
// Circular word buffer with occupancy count and sticky overflow flag.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   i_clear          - synchronous flush (pointers, count, overflow)
//   i_wr_valid/data  - write strobe and word
//   i_pop            - remove head word this edge (caller guarantees !o_empty)
//   o_head           - word at the read pointer
//   o_count          - words held, 0..2**DEPTH_LOG2
//   o_empty/o_full   - occupancy flags
//   o_overflow       - sticky: a write was dropped because the buffer was full
// -----------------------------------------------------------------------------
module uart_word_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_wr_valid,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow
);
  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  w_accept;
  logic                  w_drop;

  // A full buffer still takes a word when the head leaves on the same edge.
  assign w_accept = i_wr_valid && !i_clear && (!o_full || i_pop);
  // A write coinciding with clear is discarded silently, not as an overflow.
  assign w_drop   = i_wr_valid && !i_clear && o_full && !i_pop;

  // NOTE: storage has no reset; stale contents are unreachable because
  // the pointers and count are reset, and omitting it keeps the array a RAM.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers are exactly DEPTH_LOG2 bits, so increments wrap modulo depth.
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == FULL_COUNT);
  assign o_overflow = r_overflow;

endmodule : uart_word_fifo

// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
// Streaming byte-transform stage between a UART receiver and transmitter.
// Received words are buffered, transformed per 'mode' when popped, and offered
// to the transmitter over a valid/ready handshake.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   bus (slave)  - rx strobe in, tx valid/ready handshake out
//   mode         - 00 PASS, 01 INC, 10 DEC, 11 INV (sampled at the pop edge)
//   enable       - 1 = pop and transmit, 0 = buffer only
//   clear        - synchronous flush of buffer, overflow flag and TX path
//   count/empty/full/overflow - buffer status
// -----------------------------------------------------------------------------
module uart_echo_fifo
  import uart_echo_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDEND     = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_echo_fifo_if.slave     bus,
  input  logic [1:0]          mode,
  input  logic                enable,
  input  logic                clear,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow
);
  localparam logic [DATA_W-1:0] ADDEND_W = ADDEND[DATA_W-1:0];

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;

  // Arithmetic is DATA_W wide, so INC/DEC wrap modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] f_transform(input logic [DATA_W-1:0] d,
                                                     input logic [1:0]        m);
    unique case (mode_e'(m))
      MODE_PASS: return d;
      MODE_INC:  return d + ADDEND_W;
      MODE_DEC:  return d - ADDEND_W;
      MODE_INV:  return ~d;
    endcase
  endfunction

  // Pop only from IDLE; clear overrides any pop on its edge.
  assign w_pop = (r_state == ST_IDLE) && enable && !empty && !clear;

  uart_word_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (clear),
    .i_wr_valid (bus.rx_valid),
    .i_wr_data  (bus.rx_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tx_data <= '0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) begin
          // Transform is captured here, so later mode changes leave it intact.
          r_tx_data <= f_transform(w_head, mode);
          r_state   <= ST_SEND;
        end
        ST_SEND: if (bus.tx_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_valid = (r_state == ST_SEND);
  assign bus.tx_data  = r_tx_data;

endmodule : uart_echo_fifo

// File: tb/tb_uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_fifo
// Self-checking bench for uart_echo_fifo. A queue-based reference model tracks
// buffered words, the word in flight and the overflow flag; every cycle the
// DUT outputs are compared against it, plus directed checks on sent words.
// -----------------------------------------------------------------------------
module tb_uart_echo_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int ADDEND     = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          mode;
  logic                enable;
  logic                clear;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                overflow;

  uart_echo_fifo_if #(.DATA_W(DATA_W)) bus ();

  uart_echo_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ADDEND     (ADDEND)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mode     (mode),
    .enable   (enable),
    .clear    (clear),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_busy;
  logic [7:0] m_tx;
  logic [7:0] sent[$];

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m);
    int v;
    case (m)
      2'd0:    v = d;
      2'd1:    v = (d + ADDEND) % 256;
      2'd2:    v = (d + 256 - ADDEND) % 256;
      default: v = 255 - d;
    endcase
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    m_tx   = 8'h00;
  endtask

  task automatic compare_all();
    check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, m_busy});
    if (m_busy) check("tx_data", {24'd0, bus.tx_data}, {24'd0, m_tx});
    check("count",    {27'd0, count},    q.size());
    check("empty",    {31'd0, empty},    {31'd0, q.size() == 0});
    check("full",     {31'd0, full},     {31'd0, q.size() == DEPTH});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    bit pop;
    if (bus.tx_valid && bus.tx_ready && !clear) sent.push_back(bus.tx_data);
    pop = !m_busy && enable && (q.size() != 0);
    if (clear) begin
      q.delete();
      m_ovf  = 1'b0;
      m_busy = 1'b0;
    end else begin
      if (pop) begin
        m_tx = xf(q[0], mode);
        void'(q.pop_front());
      end
      if (bus.rx_valid) begin
        if (q.size() < DEPTH) q.push_back(bus.rx_data);
        else m_ovf = 1'b1;
      end
      if (pop) m_busy = 1'b1;
      else if (m_busy && bus.tx_ready) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_rx(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    mode         = 2'd0;
    enable       = 1'b0;
    clear        = 1'b0;
    model_reset();

    // Reset values
    #2 reset = 1'b1;
    #1;
    compare_all();
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: INC of 0x41 with two-cycle latency, then back to IDLE
    mode = 2'd1; enable = 1'b1; bus.tx_ready = 1'b1;
    send_rx(8'h41);
    check("t1_not_yet", {31'd0, bus.tx_valid}, 32'd0);
    tick();
    check("t1_valid_n2", {31'd0, bus.tx_valid}, 32'd1);
    check("t1_data", {24'd0, bus.tx_data}, 32'h42);
    tick();
    check("t1_idle", {31'd0, bus.tx_valid}, 32'd0);
    check("t1_count", {27'd0, count}, 32'd0);

    // 2: wrap cases and inversion
    send_rx(8'hFF); tick();
    check("t2_inc_wrap", {24'd0, bus.tx_data}, 32'h00);
    tick();
    mode = 2'd2;
    send_rx(8'h00); tick();
    check("t2_dec_wrap", {24'd0, bus.tx_data}, 32'hFF);
    tick();
    mode = 2'd3;
    send_rx(8'hA5); tick();
    check("t2_inv", {24'd0, bus.tx_data}, 32'h5A);
    tick();

    // 3: buffer 9 words with enable=0; ninth overflows
    enable = 1'b0; mode = 2'd0;
    for (int i = 1; i <= 9; i++) begin
      send_rx(i[7:0]);
      if (i == 8) check("t3_full8", {31'd0, full}, 32'd1);
    end
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    check("t3_count", {27'd0, count}, 32'd8);
    sent.delete();
    enable = 1'b1; bus.tx_ready = 1'b1;
    repeat (20) tick();
    check("t3_nsent", sent.size(), 32'd8);
    for (int i = 0; i < 8 && i < sent.size(); i++)
      check("t3_order", {24'd0, sent[i]}, i + 1);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);

    // 4: back-pressure holds the word; mode changes do not alter it
    bus.tx_ready = 1'b0; mode = 2'd1;
    send_rx(8'h10); tick();
    for (int i = 0; i < 20; i++) begin
      mode = 2'($urandom_range(0, 3));
      tick();
      check("t4_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("t4_data", {24'd0, bus.tx_data}, 32'h11);
    end
    bus.tx_ready = 1'b1; tick(); tick();

    // 5: full in IDLE, write on the pop edge is accepted
    enable = 1'b0; mode = 2'd0;
    for (int i = 0; i < 8; i++) send_rx(8'h20 + i[7:0]);
    check("t5_full", {31'd0, full}, 32'd1);
    enable = 1'b1; bus.tx_ready = 1'b0;
    send_rx(8'h99);
    check("t5_count", {27'd0, count}, 32'd8);
    check("t5_no_ovf", {31'd0, overflow}, 32'd0);
    check("t5_sending", {31'd0, bus.tx_valid}, 32'd1);

    // 6: clear in SEND with 3 queued words, rx on the clear edge
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send_rx(8'h60 + i[7:0]);
    enable = 1'b1; tick();
    check("t6_queued", {27'd0, count}, 32'd3);
    clear = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    tick();
    clear = 1'b0; bus.rx_valid = 1'b0;
    check("t6_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t6_count", {27'd0, count}, 32'd0);
    check("t6_ovf", {31'd0, overflow}, 32'd0);

    // Async reset in the middle of a SEND
    send_rx(8'h33); send_rx(8'h34);
    check("t6_pre_rst", {31'd0, bus.tx_valid}, 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t6_rst_data", {24'd0, bus.tx_data}, 32'h0);
    #2 reset = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
      mode         = 2'($urandom_range(0, 3));
      enable       = ($urandom_range(0, 3) != 0);
      bus.tx_ready = 1'($urandom_range(0, 1));
      clear        = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_echo_fifo
